// File: rtl/slurm_irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM state
// encoding, STATUS field layout and the priority-pick helper.
package slurm_irq_pkg;

  localparam int NUM_SOURCES = 16;

  localparam logic [1:0] OFF_ENABLE  = 2'd0;
  localparam logic [1:0] OFF_PENDING = 2'd1;
  localparam logic [1:0] OFF_FORCE   = 2'd2;
  localparam logic [1:0] OFF_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_HOLDOFF = 2'b01,
    ST_ASSERT  = 2'b10
  } irq_state_t;

  localparam int STATUS_IRQ_LSB   = 0;
  localparam int STATUS_STATE_LSB = 4;

  typedef struct packed {
    logic       valid;
    logic [3:0] index;
  } candidate_t;

  // Lowest-numbered set bit wins; scanning downward lets bit 0 overwrite last.
  function automatic candidate_t lowest_set(input logic [NUM_SOURCES-1:0] v);
    candidate_t c;
    c.valid = 1'b0;
    c.index = 4'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (v[i]) begin
        c.valid = 1'b1;
        c.index = 4'(i);
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] pack_status(input irq_state_t st, input logic [3:0] idx);
    logic [15:0] s;
    s = 16'h0000;
    s[STATUS_STATE_LSB +: 2] = st;
    s[STATUS_IRQ_LSB +: 4]   = idx;
    return s;
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector for one
// asynchronous interrupt line.
module irq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [2:0] primed;

  // primed holds off detection until prev carries a real post-reset sample,
  // so a line that was already high at reset release does not count as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      prev   <= 1'b0;
      primed <= 3'b000;
      rise   <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      prev   <= sync;
      primed <= {primed[1:0], 1'b1};
      rise   <= sync & ~prev & primed[2];
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Memory-mapped 16-source interrupt controller: edge-captured pending bits,
// enable mask, fixed priority (bit 0 highest) and a one-cycle holdoff after each request.
module interrupt_controller
  import slurm_irq_pkg::*;
#(
  parameter int                      BITS         = 16,
  parameter int                      ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] BASE_ADDRESS = 16'h7000
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [15:0]             irq_lines,
  input  logic [ADDRESS_BITS-1:0] port_address,
  input  logic [BITS-1:0]         port_in,
  input  logic                    port_wr,
  input  logic                    port_rd,
  output logic [BITS-1:0]         port_out,
  output logic                    interrupt,
  output logic [3:0]              irq
);

  logic [NUM_SOURCES-1:0]  rise;
  logic [NUM_SOURCES-1:0]  enable;
  logic [NUM_SOURCES-1:0]  pending;
  logic [NUM_SOURCES-1:0]  pending_next;
  logic [15:0]             wdata;
  logic [15:0]             rd_data;
  logic [ADDRESS_BITS-1:0] offset_full;
  logic [1:0]              offset;
  logic                    hit;
  logic                    wr_enable;
  logic                    wr_pending;
  logic                    wr_force;
  logic                    latched_live;
  candidate_t              cand;
  irq_state_t              state;

  for (genvar n = 0; n < NUM_SOURCES; n++) begin : g_src
    irq_edge_sync u_sync (
      .clk  (CLK),
      .rst  (RSTb),
      .din  (irq_lines[n]),
      .rise (rise[n])
    );
  end

  assign wdata        = 16'(port_in);
  assign cand         = lowest_set(pending & enable);
  assign latched_live = pending[irq] & enable[irq];

  // Address decode; addresses below the base wrap to large offsets and miss.
  always_comb begin
    offset_full = port_address - BASE_ADDRESS;
    hit         = (offset_full < ADDRESS_BITS'(32'd4));
    offset      = offset_full[1:0];
    wr_enable   = port_wr & hit & (offset == OFF_ENABLE);
    wr_pending  = port_wr & hit & (offset == OFF_PENDING);
    wr_force    = port_wr & hit & (offset == OFF_FORCE);
  end

  // Next PENDING: clear first, then force and edge sets so a set always wins.
  always_comb begin
    pending_next = pending;
    if (wr_pending) begin
      pending_next = pending_next & ~wdata;
    end else begin
      pending_next = pending_next;
    end
    if (wr_force) begin
      pending_next = pending_next | wdata;
    end else begin
      pending_next = pending_next;
    end
    pending_next = pending_next | rise;
  end

  // Read-data mux for the register window.
  always_comb begin
    rd_data = 16'h0000;
    case (offset)
      OFF_ENABLE:  rd_data = enable;
      OFF_PENDING: rd_data = pending;
      OFF_STATUS:  rd_data = pack_status(state, irq);
      default:     rd_data = 16'h0000;
    endcase
  end

  // Register file and registered read port.
  always_ff @(posedge CLK or posedge RSTb) begin
    if (RSTb) begin
      enable   <= 16'h0000;
      pending  <= 16'h0000;
      port_out <= {BITS{1'b0}};
    end else begin
      if (wr_enable) begin
        enable <= wdata;
      end
      pending <= pending_next;
      if (port_rd && hit) begin
        port_out <= BITS'(rd_data);
      end else begin
        port_out <= {BITS{1'b0}};
      end
    end
  end

  // Request FSM; irq is frozen while asserted so the CPU sees a stable index.
  always_ff @(posedge CLK or posedge RSTb) begin
    if (RSTb) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      irq       <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand.valid) begin
            irq       <= cand.index;
            interrupt <= 1'b1;
            state     <= ST_ASSERT;
          end else begin
            interrupt <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (!latched_live) begin
            interrupt <= 1'b0;
            state     <= ST_HOLDOFF;
          end else begin
            interrupt <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: register vector table plus hand-written interrupt sequences,
// with read results checked through an expected-value queue.
module tb_interrupt_controller;

  localparam logic [15:0] BASE     = 16'h7000;
  localparam logic [15:0] A_EN     = 16'h7000;
  localparam logic [15:0] A_PEND   = 16'h7001;
  localparam logic [15:0] A_FORCE  = 16'h7002;
  localparam logic [15:0] A_STATUS = 16'h7003;

  logic        CLK;
  logic        RSTb;
  logic [15:0] irq_lines;
  logic [15:0] port_address;
  logic [15:0] port_in;
  logic        port_wr;
  logic        port_rd;
  logic [15:0] port_out;
  logic        interrupt;
  logic [3:0]  irq;

  int n_pass;
  int n_total;

  typedef struct {
    string       name;
    logic [15:0] value;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        is_read;
    logic [15:0] addr;
    logic [15:0] data;
    string       name;
  } vec_t;
  vec_t tbl [0:14];

  interrupt_controller dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .irq_lines    (irq_lines),
    .port_address (port_address),
    .port_in      (port_in),
    .port_wr      (port_wr),
    .port_rd      (port_rd),
    .port_out     (port_out),
    .interrupt    (interrupt),
    .irq          (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  task automatic check_int(input string name, input logic exp_int, input logic [3:0] exp_irq);
    check({name, "_interrupt"}, {15'h0000, interrupt}, {15'h0000, exp_int});
    if (exp_int) check({name, "_irq"}, {12'h000, irq}, {12'h000, exp_irq});
  endtask

  task automatic write_reg(input logic [15:0] addr, input logic [15:0] data);
    port_address = addr;
    port_in      = data;
    port_wr      = 1'b1;
    tick(1);
    port_wr      = 1'b0;
  endtask

  task automatic read_reg(input logic [15:0] addr, input logic [15:0] exp, input string name);
    exp_t e;
    port_address = addr;
    port_rd      = 1'b1;
    sb_q.push_back('{name: name, value: exp});
    tick(1);
    port_rd = 1'b0;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty, got 0x%04h", name, port_out);
    end else begin
      e = sb_q.pop_front();
      check(e.name, port_out, e.value);
    end
  endtask

  // Raise the given lines for one sampling edge, then drop them.
  task automatic pulse(input logic [15:0] mask);
    irq_lines = irq_lines | mask;
    tick(1);
    irq_lines = irq_lines & ~mask;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    RSTb         = 1'b1;
    irq_lines    = 16'h0000;
    port_address = 16'h0000;
    port_in      = 16'h0000;
    port_wr      = 1'b0;
    port_rd      = 1'b0;

    tbl[0]  = '{1'b0, A_EN,           16'h00F0, "wr_en"};
    tbl[1]  = '{1'b1, A_EN,           16'h00F0, "en_rw"};
    tbl[2]  = '{1'b1, A_PEND,         16'h0000, "pend_after_reset"};
    tbl[3]  = '{1'b1, A_STATUS,       16'h0000, "status_idle"};
    tbl[4]  = '{1'b0, BASE + 16'd4,   16'hFFFF, "wr_above"};
    tbl[5]  = '{1'b1, A_EN,           16'h00F0, "above_window_ignored"};
    tbl[6]  = '{1'b1, BASE + 16'd4,   16'h0000, "rd_outside_window"};
    tbl[7]  = '{1'b0, BASE - 16'd1,   16'hFFFF, "wr_below"};
    tbl[8]  = '{1'b1, A_EN,           16'h00F0, "below_window_ignored"};
    tbl[9]  = '{1'b0, A_FORCE,        16'h0100, "wr_force"};
    tbl[10] = '{1'b1, A_PEND,         16'h0100, "force_sets_pending"};
    tbl[11] = '{1'b0, A_PEND,         16'h0100, "wr_w1c"};
    tbl[12] = '{1'b1, A_PEND,         16'h0000, "w1c_clears"};
    tbl[13] = '{1'b0, A_EN,           16'h0000, "wr_en_zero"};
    tbl[14] = '{1'b1, A_EN,           16'h0000, "en_cleared"};

    // Reset state
    tick(3);
    check_int("reset", 1'b0, 4'd0);
    check("reset_irq", {12'h000, irq}, 16'h0000);
    check("reset_port_out", port_out, 16'h0000);
    RSTb = 1'b0;
    tick(4);

    // Register vectors
    for (int i = 0; i <= 14; i++) begin
      if (tbl[i].is_read) read_reg(tbl[i].addr, tbl[i].data, tbl[i].name);
      else write_reg(tbl[i].addr, tbl[i].data);
    end
    tick(1);
    check("port_out_idle", port_out, 16'h0000);

    // Five-cycle latency and STATUS readback
    write_reg(A_EN, 16'h0008);
    pulse(16'h0008);
    tick(3);
    check_int("lat_cycle4", 1'b0, 4'd0);
    tick(1);
    check_int("lat_cycle5", 1'b1, 4'd3);
    read_reg(A_STATUS, 16'h0023, "status_assert");
    write_reg(A_PEND, 16'h0008);
    tick(3);
    check_int("lat_cleanup", 1'b0, 4'd0);

    // Simultaneous edges, priority, holdoff
    write_reg(A_EN, 16'hFFFF);
    pulse(16'h0024);
    tick(4);
    check_int("prio_first", 1'b1, 4'd2);
    write_reg(A_PEND, 16'h0004);
    tick(1);
    check_int("holdoff", 1'b0, 4'd0);
    tick(1);
    check_int("idle_after_holdoff", 1'b0, 4'd0);
    tick(1);
    check_int("prio_second", 1'b1, 4'd5);
    write_reg(A_PEND, 16'h0020);
    tick(3);

    // Latched irq ignores a newer higher-priority source
    pulse(16'h0080);
    tick(4);
    check_int("latch_7", 1'b1, 4'd7);
    pulse(16'h0002);
    tick(5);
    check_int("latch_hold_7", 1'b1, 4'd7);
    read_reg(A_PEND, 16'h0082, "pend_7_and_1");
    write_reg(A_PEND, 16'h0080);
    tick(3);
    check_int("after_7_cleared", 1'b1, 4'd1);
    write_reg(A_PEND, 16'h0002);
    tick(3);
    check_int("latch_cleanup", 1'b0, 4'd0);

    // Edge set beats same-cycle W1C
    write_reg(A_EN, 16'h0000);
    pulse(16'h0010);
    tick(2);
    write_reg(A_PEND, 16'h0010);
    read_reg(A_PEND, 16'h0010, "set_beats_w1c");
    write_reg(A_PEND, 16'h0010);
    read_reg(A_PEND, 16'h0000, "w1c_later_clears");

    // Disabling the latched source drops the request but keeps PENDING
    write_reg(A_EN, 16'h0001);
    write_reg(A_FORCE, 16'h0001);
    tick(1);
    check_int("force_assert", 1'b1, 4'd0);
    write_reg(A_EN, 16'h0000);
    tick(1);
    check_int("disable_drop", 1'b0, 4'd0);
    read_reg(A_PEND, 16'h0001, "pend_kept");
    write_reg(A_PEND, 16'h0001);
    tick(2);

    // Asynchronous reset during ASSERT with a line held high
    write_reg(A_EN, 16'h0001);
    write_reg(A_FORCE, 16'h0001);
    tick(1);
    check_int("pre_reset_assert", 1'b1, 4'd0);
    irq_lines = 16'h0200;
    tick(2);
    #2 RSTb = 1'b1;
    #1 check_int("async_reset_drop", 1'b0, 4'd0);
    check("async_reset_irq", {12'h000, irq}, 16'h0000);
    tick(2);
    RSTb = 1'b0;
    tick(4);
    read_reg(A_EN, 16'h0000, "post_reset_en");
    read_reg(A_PEND, 16'h0000, "post_reset_pend");
    read_reg(A_STATUS, 16'h0000, "post_reset_status");
    write_reg(A_EN, 16'hFFFF);
    tick(8);
    check_int("held_line_quiet", 1'b0, 4'd0);
    read_reg(A_PEND, 16'h0000, "held_line_no_pend");
    irq_lines = 16'h0000;
    tick(3);
    irq_lines = 16'h0200;
    tick(5);
    check_int("rearmed_line", 1'b1, 4'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
